// File: rtl/qos_wrr_scheduler.sv
// qos_wrr_scheduler: work-conserving weighted round-robin drain of four
// per-class FWFT FIFOs into one output FIFO, one word per cycle.
module qos_wrr_scheduler #(
  parameter int DATA_W = 12,
  parameter int W0     = 4,
  parameter int W1     = 3,
  parameter int W2     = 2,
  parameter int W3     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic [3:0]            empty,
  input  logic [4*DATA_W-1:0]   fifo_data,
  input  logic                  out_almost_full,
  output logic [3:0]            pop,
  output logic                  push_out,
  output logic [DATA_W-1:0]     data_out,
  output logic                  idle
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q;
  logic [1:0]          ptr_q, ptr_d;
  logic [3:0]          credit_q, credit_d;
  logic                push_q;
  logic [DATA_W-1:0]   data_q;

  logic                elig;
  logic [1:0]          g;
  logic [3:0]          c;

  function automatic logic [3:0] wt(input logic [1:0] k);
    case (k)
      2'd0:    wt = 4'(W0);
      2'd1:    wt = 4'(W1);
      2'd2:    wt = 4'(W2);
      default: wt = 4'(W3);
    endcase
  endfunction

  // Grant: first non-empty class scanning from ptr; pops are withheld during
  // reset so no word is lost when the in-flight register is cleared.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = ptr_q;
    g     = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && !empty[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
    elig = !reset && (state_q == RUN) && active && !out_almost_full && (empty != 4'hF);
    pop  = elig ? (4'b0001 << g) : 4'b0000;
    c    = (g == ptr_q) ? credit_q : wt(g);
    ptr_d    = ptr_q;
    credit_d = credit_q;
    if (elig) begin
      if (c == 4'd1) begin
        ptr_d    = g + 2'd1;
        credit_d = wt(g + 2'd1);
      end else begin
        ptr_d    = g;
        credit_d = c - 4'd1;
      end
    end
  end

  // FSM, round pointer/credit and the single-slot output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      credit_q <= 4'(W0);
      push_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        IDLE:    if (active)  state_q <= RUN;
        default: if (!active) state_q <= IDLE;
      endcase
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      push_q   <= elig;
      if (elig) data_q <= fifo_data[int'(g)*DATA_W +: DATA_W];
    end
  end

  assign push_out = push_q;
  assign data_out = data_q;
  assign idle     = (&empty) && !push_q && (state_q == IDLE);

endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// Scoreboard bench for qos_wrr_scheduler: FIFO model drives the inputs,
// expected class order is queued up front and checked as words are pushed.
module tb_qos_wrr_scheduler;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            reset, active, afull;
  logic [3:0]      empty;
  logic [4*DW-1:0] fifo_data;
  logic [3:0]      pop;
  logic            push_out, idle;
  logic [DW-1:0]   data_out;

  qos_wrr_scheduler #(.DATA_W(DW), .W0(4), .W1(3), .W2(2), .W3(1)) dut (
    .clk(clk), .reset(reset), .active(active), .empty(empty),
    .fifo_data(fifo_data), .out_almost_full(afull), .pop(pop),
    .push_out(push_out), .data_out(data_out), .idle(idle)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[4][$];
  int            exp_cls[$];
  int            nxt[4];
  int            total = 0, bad = 0;
  int            cyc = 0, n_push = 0, n_popc = 0;
  logic [3:0]    pop_s;
  logic          push_s, idle_s;
  logic [DW-1:0] data_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      empty[k] = (fq[k].size() == 0);
      fifo_data[k*DW +: DW] = (fq[k].size() != 0) ? fq[k][0] : '0;
    end
  endtask

  task automatic load(input int k, input int n);
    for (int i = 0; i < n; i++) fq[k].push_back({2'(k), 10'(i)});
    refresh();
  endtask

  task automatic add_round(input int n0, input int n1, input int n2, input int n3);
    for (int i = 0; i < n0; i++) exp_cls.push_back(0);
    for (int i = 0; i < n1; i++) exp_cls.push_back(1);
    for (int i = 0; i < n2; i++) exp_cls.push_back(2);
    for (int i = 0; i < n3; i++) exp_cls.push_back(3);
  endtask

  // One clock: sample/check at negedge, update FIFO model just after posedge.
  task automatic tick();
    int c;
    @(negedge clk);
    pop_s = pop; push_s = push_out; idle_s = idle; data_s = data_out;
    if (pop_s != 0) begin
      n_popc++;
      chk("pop_onehot", 32'($countones(pop_s)), 32'd1);
      chk("pop_nonempty", 32'(pop_s & empty), 32'd0);
    end
    if (push_s) begin
      n_push++;
      if (exp_cls.size() == 0) chk("extra_push", 32'd1, 32'd0);
      else begin
        c = exp_cls.pop_front();
        chk("data_out", 32'(data_s), 32'({2'(c), 10'(nxt[c])}));
        nxt[c]++;
      end
    end
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < 4; k++)
      if (pop_s[k] && fq[k].size() != 0) void'(fq[k].pop_front());
    refresh();
  endtask

  task automatic run_pops(input int k, output int span);
    int start, first;
    start = n_popc; first = -1; span = 0;
    for (int i = 0; i < 300 && (n_popc - start) < k; i++) begin
      tick();
      if (pop_s != 0 && first < 0) first = cyc;
    end
    chk("pop_count", 32'(n_popc - start), 32'(k));
    span = cyc - first + 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_cls.size() != 0; i++) tick();
    chk("drained", 32'(exp_cls.size()), 32'd0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; active = 1'b0; afull = 1'b0;
    for (int k = 0; k < 4; k++) begin fq[k].delete(); nxt[k] = 0; end
    exp_cls.delete();
    refresh();
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int span, p0, n0;
    reset = 1'b1; active = 1'b0; afull = 1'b0;
    for (int k = 0; k < 4; k++) nxt[k] = 0;
    refresh();

    // Reset state
    do_reset();
    tick();
    chk("rst_push", 32'(push_s), 32'd0);
    chk("rst_data", 32'(data_s), 32'd0);
    chk("rst_pop", 32'(pop_s), 32'd0);
    chk("rst_idle", 32'(idle_s), 32'd1);

    // All loaded: two full rounds, back to back
    for (int k = 0; k < 4; k++) load(k, 12);
    add_round(4, 3, 2, 1); add_round(4, 3, 2, 1);
    active = 1'b1;
    run_pops(20, span);
    chk("full_span", 32'(span), 32'd20);
    active = 1'b0;
    drain();

    // P1 empty: skipped without a bubble
    do_reset();
    load(0, 12); load(2, 12); load(3, 12);
    add_round(4, 0, 2, 1); add_round(4, 0, 2, 1);
    active = 1'b1;
    run_pops(14, span);
    chk("skip_span", 32'(span), 32'd14);
    active = 1'b0;
    drain();

    // almost_full for 3 cycles with class-0 credit at 2
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 12);
    add_round(2, 0, 0, 0); add_round(2, 3, 2, 1);
    active = 1'b1;
    run_pops(2, span);
    afull = 1'b1;
    n0 = n_push; p0 = n_popc;
    tick(); tick(); tick();
    chk("af_pushes", 32'(n_push - n0), 32'd1);
    chk("af_pops", 32'(n_popc - p0), 32'd0);
    afull = 1'b0;
    run_pops(8, span);
    active = 1'b0;
    drain();

    // Only P3 with 5 words, then idle one cycle after the last push
    do_reset();
    load(3, 5);
    add_round(0, 0, 0, 5);
    active = 1'b1;
    run_pops(5, span);
    chk("p3_span", 32'(span), 32'd5);
    active = 1'b0;
    tick();
    chk("p3_last_push", 32'(push_s), 32'd1);
    chk("p3_idle_early", 32'(idle_s), 32'd0);
    tick();
    chk("p3_idle", 32'(idle_s), 32'd1);
    chk("p3_drained", 32'(exp_cls.size()), 32'd0);

    // active drops after 2 class-0 pops; round resumes where it stopped
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 12);
    add_round(2, 0, 0, 0); add_round(2, 3, 2, 1);
    active = 1'b1;
    run_pops(2, span);
    active = 1'b0;
    n0 = n_push; p0 = n_popc;
    tick(); tick();
    chk("act_trail_push", 32'(n_push - n0), 32'd1);
    chk("act_no_pop", 32'(n_popc - p0), 32'd0);
    active = 1'b1;
    run_pops(8, span);
    active = 1'b0;
    drain();

    // Reset mid-stream: restart at class 0 with full credit
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 12);
    add_round(4, 1, 0, 0);
    active = 1'b1;
    run_pops(5, span);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_push", 32'(push_s), 32'd0);
    chk("rst_mid_pop", 32'(pop_s), 32'd0);
    chk("rst_mid_exp", 32'(exp_cls.size()), 32'd0);
    add_round(4, 3, 2, 1);
    run_pops(10, span);
    active = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
